// File: rtl/data_mem_responder.sv
// Multi-channel fixed-latency memory responder with per-channel read/write FSMs.
// Backing word array is shared; a backdoor preload port allows boot/test loads.
module data_mem_responder #(
    parameter int NUM_CHANNELS  = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 8,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_CHANNELS-1:0]               read_valid,
    input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] read_address,
    output logic [NUM_CHANNELS-1:0]               read_ready,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]    read_data,
    input  logic [NUM_CHANNELS-1:0]               write_valid,
    input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] write_address,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    write_data,
    output logic [NUM_CHANNELS-1:0]               write_ready,
    input  logic                                  preload_en,
    input  logic [ADDRESS_WIDTH-1:0]              preload_address,
    input  logic [DATA_WIDTH-1:0]                 preload_data,
    output logic                                  busy
);

    localparam int AW    = ADDRESS_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

    logic [DW-1:0] mem_q [DEPTH];

    logic [1:0]    rd_state_q [NUM_CHANNELS];
    logic [1:0]    rd_state_d [NUM_CHANNELS];
    logic [3:0]    rd_cnt_q   [NUM_CHANNELS];
    logic [3:0]    rd_cnt_d   [NUM_CHANNELS];
    logic [AW-1:0] rd_addr_q  [NUM_CHANNELS];
    logic [AW-1:0] rd_addr_d  [NUM_CHANNELS];
    logic [DW-1:0] rd_data_q  [NUM_CHANNELS];
    logic [DW-1:0] rd_data_d  [NUM_CHANNELS];

    logic [1:0]    wr_state_q [NUM_CHANNELS];
    logic [1:0]    wr_state_d [NUM_CHANNELS];
    logic [3:0]    wr_cnt_q   [NUM_CHANNELS];
    logic [3:0]    wr_cnt_d   [NUM_CHANNELS];
    logic [AW-1:0] wr_addr_q  [NUM_CHANNELS];
    logic [AW-1:0] wr_addr_d  [NUM_CHANNELS];
    logic [DW-1:0] wr_data_q  [NUM_CHANNELS];
    logic [DW-1:0] wr_data_d  [NUM_CHANNELS];

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            rd_state_d[c] = rd_state_q[c];
            rd_cnt_d[c]   = rd_cnt_q[c];
            rd_addr_d[c]  = rd_addr_q[c];
            rd_data_d[c]  = rd_data_q[c];
            unique case (rd_state_q[c])
                S_IDLE: begin
                    if (read_valid[c]) begin
                        rd_addr_d[c]  = read_address[c*AW +: AW];
                        rd_cnt_d[c]   = RD_LOAD;
                        rd_state_d[c] = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    rd_cnt_d[c] = rd_cnt_q[c] - 4'd1;
                    if (rd_cnt_q[c] == 4'd1) rd_state_d[c] = S_RESP;
                end
                S_RESP:  rd_state_d[c] = S_DRAIN;
                S_DRAIN: if (!read_valid[c]) rd_state_d[c] = S_IDLE;
            endcase
            // Sample on the edge entering RESPOND: sees pre-commit data.
            if (rd_state_d[c] == S_RESP && rd_state_q[c] != S_RESP)
                rd_data_d[c] = mem_q[rd_addr_d[c]];
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            wr_state_d[c] = wr_state_q[c];
            wr_cnt_d[c]   = wr_cnt_q[c];
            wr_addr_d[c]  = wr_addr_q[c];
            wr_data_d[c]  = wr_data_q[c];
            unique case (wr_state_q[c])
                S_IDLE: begin
                    if (write_valid[c]) begin
                        wr_addr_d[c]  = write_address[c*AW +: AW];
                        wr_data_d[c]  = write_data[c*DW +: DW];
                        wr_cnt_d[c]   = WR_LOAD;
                        wr_state_d[c] = (WRITE_LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wr_cnt_d[c] = wr_cnt_q[c] - 4'd1;
                    if (wr_cnt_q[c] == 4'd1) wr_state_d[c] = S_RESP;
                end
                S_RESP:  wr_state_d[c] = S_DRAIN;
                S_DRAIN: if (!write_valid[c]) wr_state_d[c] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                rd_state_q[c] <= S_IDLE;
                rd_cnt_q[c]   <= '0;
                rd_addr_q[c]  <= '0;
                rd_data_q[c]  <= '0;
                wr_state_q[c] <= S_IDLE;
                wr_cnt_q[c]   <= '0;
                wr_addr_q[c]  <= '0;
                wr_data_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                rd_state_q[c] <= rd_state_d[c];
                rd_cnt_q[c]   <= rd_cnt_d[c];
                rd_addr_q[c]  <= rd_addr_d[c];
                rd_data_q[c]  <= rd_data_d[c];
                wr_state_q[c] <= wr_state_d[c];
                wr_cnt_q[c]   <= wr_cnt_d[c];
                wr_addr_q[c]  <= wr_addr_d[c];
                wr_data_q[c]  <= wr_data_d[c];
            end
        end
    end

    // Later assignments win: preload first, then channels in ascending order.
    always_ff @(posedge clk) begin
        if (preload_en) mem_q[preload_address] <= preload_data;
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (wr_state_q[c] == S_RESP)
                    mem_q[wr_addr_q[c]] <= wr_data_q[c];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            read_ready[c]            = (rd_state_q[c] == S_RESP);
            write_ready[c]           = (wr_state_q[c] == S_RESP);
            read_data[c*DW +: DW]    = rd_data_q[c];
            busy = busy | (rd_state_q[c] != S_IDLE) | (wr_state_q[c] != S_IDLE);
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected pulses are queued at
// issue time and retired by a negedge monitor; scenario tasks add inline checks.
module tb_data_mem_responder;

    localparam int NCH = 8;
    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int LAT = 2;

    typedef struct {
        bit          rd;
        int          ch;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [NCH-1:0]    read_valid;
    logic [NCH*AW-1:0] read_address;
    logic [NCH-1:0]    read_ready;
    logic [NCH*DW-1:0] read_data;
    logic [NCH-1:0]    write_valid;
    logic [NCH*AW-1:0] write_address;
    logic [NCH*DW-1:0] write_data;
    logic [NCH-1:0]    write_ready;
    logic              preload_en;
    logic [AW-1:0]     preload_address;
    logic [DW-1:0]     preload_data;
    logic              busy;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   hold_rd = 0;

    data_mem_responder dut (
        .clk(clk), .reset(reset),
        .read_valid(read_valid), .read_address(read_address),
        .read_ready(read_ready), .read_data(read_data),
        .write_valid(write_valid), .write_address(write_address),
        .write_data(write_data), .write_ready(write_ready),
        .preload_en(preload_en), .preload_address(preload_address),
        .preload_data(preload_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int find(input bit rd, input int ch);
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].rd == rd && sb[i].ch == ch) return i;
        return -1;
    endfunction

    // Retire every ready pulse against the scoreboard.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (read_ready[c]) begin
                int idx;
                idx = find(1'b1, c);
                n_checks++;
                if (idx < 0) begin
                    n_fail++;
                    $display("FAIL rd_pulse ch%0d: unexpected pulse at cycle %0d", c, cyc);
                end else begin
                    if (read_data[c*DW +: DW] !== sb[idx].data || cyc != sb[idx].cyc) begin
                        n_fail++;
                        $display("FAIL rd_resp ch%0d: got %h @%0d expected %h @%0d",
                                 c, read_data[c*DW +: DW], cyc, sb[idx].data, sb[idx].cyc);
                    end
                    sb.delete(idx);
                end
            end
            if (write_ready[c]) begin
                int idx;
                idx = find(1'b0, c);
                n_checks++;
                if (idx < 0) begin
                    n_fail++;
                    $display("FAIL wr_pulse ch%0d: unexpected pulse at cycle %0d", c, cyc);
                end else begin
                    if (cyc != sb[idx].cyc) begin
                        n_fail++;
                        $display("FAIL wr_resp ch%0d: got cycle %0d expected %0d",
                                 c, cyc, sb[idx].cyc);
                    end
                    sb.delete(idx);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            if (read_ready[c] && !hold_rd) read_valid[c] = 1'b0;
            if (write_ready[c]) write_valid[c] = 1'b0;
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        preload_en = 1'b1; preload_address = a; preload_data = d;
        tick();
        preload_en = 1'b0;
    endtask

    task automatic issue_rd(input int ch, input logic [7:0] a, input logic [15:0] d);
        read_valid[ch] = 1'b1;
        read_address[ch*AW +: AW] = a;
        sb.push_back('{1'b1, ch, d, cyc + LAT});
    endtask

    task automatic issue_wr(input int ch, input logic [7:0] a, input logic [15:0] d);
        write_valid[ch] = 1'b1;
        write_address[ch*AW +: AW] = a;
        write_data[ch*DW +: DW] = d;
        sb.push_back('{1'b0, ch, 16'h0, cyc + LAT});
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= 50) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
            read_valid = '0;
            write_valid = '0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks += 4;
        if (read_ready !== '0) begin
            n_fail++; $display("FAIL rst_read_ready: got %h expected 0", read_ready);
        end
        if (write_ready !== '0) begin
            n_fail++; $display("FAIL rst_write_ready: got %h expected 0", write_ready);
        end
        if (read_data !== '0) begin
            n_fail++; $display("FAIL rst_read_data: got %h expected 0", read_data);
        end
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy: got %b expected 0", busy);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read_latency();
        int pulses;
        pulses = 0;
        preload(8'h10, 16'hBEEF);
        hold_rd = 1'b1;
        issue_rd(0, 8'h10, 16'hBEEF);
        repeat (5) begin
            tick();
            if (read_ready[0]) pulses++;
        end
        hold_rd = 1'b0;
        read_valid[0] = 1'b0;
        wait_done("read_latency");
        n_checks += 2;
        if (pulses != 1) begin
            n_fail++; $display("FAIL single_pulse: got %0d expected 1", pulses);
        end
        if (read_data[0 +: DW] !== 16'hBEEF) begin
            n_fail++; $display("FAIL rd_hold ch0: got %h expected beef", read_data[0 +: DW]);
        end
    endtask

    task automatic test_write_then_read();
        int n;
        bit seen;
        n = 0;
        seen = 0;
        issue_wr(3, 8'h20, 16'h1234);
        while (!seen && n < 10) begin
            tick();
            n++;
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL busy_wr: got %b expected 1", busy);
            end
            if (write_ready[3]) seen = 1;
        end
        issue_rd(5, 8'h20, 16'h1234);
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL busy_rd: got %b expected 1", busy);
            end
        end
        wait_done("write_then_read");
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_idle: got %b expected 0", busy);
        end
    endtask

    task automatic test_write_conflict();
        issue_wr(1, 8'h30, 16'hAAAA);
        issue_wr(6, 8'h30, 16'h5555);
        wait_done("conflict_wr");
        tick();
        issue_rd(0, 8'h30, 16'h5555);
        wait_done("conflict_rd");
    endtask

    task automatic test_read_before_write();
        preload(8'h40, 16'h0001);
        issue_rd(2, 8'h40, 16'h0001);
        issue_wr(4, 8'h40, 16'h0002);
        wait_done("rbw");
        tick();
        issue_rd(7, 8'h40, 16'h0002);
        wait_done("rbw_after");
    endtask

    task automatic test_all_channels();
        for (int c = 0; c < NCH; c++)
            preload(8'h60 + 8'(c), 16'hC000 + 16'(c * 'h111));
        for (int c = 0; c < NCH; c++)
            issue_rd(c, 8'h60 + 8'(c), 16'hC000 + 16'(c * 'h111));
        wait_done("all_channels");
    endtask

    task automatic test_reset_abort();
        preload(8'h50, 16'h1111);
        write_valid[0] = 1'b1;
        write_address[0 +: AW] = 8'h50;
        write_data[0 +: DW] = 16'h7777;
        tick();
        reset = 1'b1;
        write_valid[0] = 1'b0;
        repeat (2) begin
            tick();
            n_checks++;
            if (write_ready !== '0) begin
                n_fail++; $display("FAIL abort_wr_ready: got %h expected 0", write_ready);
            end
        end
        n_checks += 2;
        if (read_data !== '0) begin
            n_fail++; $display("FAIL abort_read_data: got %h expected 0", read_data);
        end
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy: got %b expected 0", busy);
        end
        reset = 1'b0;
        tick();
        issue_rd(0, 8'h50, 16'h1111);
        wait_done("abort_rd");
    endtask

    initial begin
        reset = 1'b1;
        read_valid = '0; read_address = '0;
        write_valid = '0; write_address = '0; write_data = '0;
        preload_en = 1'b0; preload_address = '0; preload_data = '0;
        test_reset();
        test_read_latency();
        test_write_then_read();
        test_write_conflict();
        test_read_before_write();
        test_all_channels();
        test_reset_abort();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
